conv_3x3_pe: RTL and testbench

- Parametrised, fully pipelined 3x3 convolution processing element for the NHWC datapath.
- Per cycle, takes a 3x3 window of CIN_PAR signed int8 channels. Computes COUT_PAR filters in parallel.
- Accumulates partial sums across channel groups until last_channel, then adds bias once.
- Emits both the raw int32 accumulator and a requantised int8 result, with optional leaky ReLU. Feeds the layer output writer.

---
 rtl/conv_pkg.sv | 40 ++++
 rtl/conv_3x3_pe_adder_tree.sv | 44 ++++
 rtl/conv_3x3_pe.sv | 161 ++++++++++++++++
 tb/tb_conv_3x3_pe.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared widths and arithmetic helpers for the 3x3 convolution PE.
package conv_pkg;
  localparam int DATA_W    = 8;
  localparam int PROD_W    = 16;
  localparam int ACC_W_DEF = 32;
  // Post-stage math runs wide so the rounding add can never overflow.
  localparam int WIDE_W    = 64;

  function automatic int tree_depth(input int n);
    return $clog2(n);
  endfunction

  // Number of live nodes at tree level lvl (level 0 = leaves).
  function automatic int tree_cnt(input int n, input int lvl);
    return (n + (1 << lvl) - 1) >> lvl;
  endfunction

  function automatic logic signed [PROD_W-1:0] mul8(input logic signed [DATA_W-1:0] a,
                                                    input logic signed [DATA_W-1:0] b);
    logic signed [PROD_W-1:0] a_w, b_w;
    a_w = PROD_W'(a);
    b_w = PROD_W'(b);
    return a_w * b_w;
  endfunction

  // Round half up, then arithmetic shift.
  function automatic logic signed [WIDE_W-1:0] round_shift(input logic signed [WIDE_W-1:0] v,
                                                           input logic [4:0] sh);
    logic signed [WIDE_W-1:0] half;
    if (sh == 5'd0) return v;
    half = WIDE_W'(1) <<< (sh - 5'd1);
    return (v + half) >>> sh;
  endfunction

  function automatic logic [DATA_W-1:0] sat_int8(input logic signed [WIDE_W-1:0] v);
    if (v > WIDE_W'(127))  return 8'h7f;
    if (v < -WIDE_W'(128)) return 8'h80;
    return v[DATA_W-1:0];
  endfunction
endpackage

// File: rtl/conv_3x3_pe_adder_tree.sv
// Pipelined binary adder tree: N leaves, one register per level, matching valid pipe.
module adder_tree_pipe import conv_pkg::*; #(
  parameter int N     = 72,
  parameter int IN_W  = PROD_W,
  parameter int D     = tree_depth(N),
  parameter int OUT_W = IN_W + D
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    vld_in,
  input  logic [N-1:0][IN_W-1:0]  in_data,
  output logic                    vld_out,
  output logic signed [OUT_W-1:0] sum
);
  logic [D-1:0] vld_pipe;

  always_ff @(posedge clk) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= D'({vld_pipe, vld_in});
  end
  assign vld_out = vld_pipe[D-1];

  // Leaves are sign-extended to the final width so no level needs resizing.
  for (genvar l = 0; l <= D; l++) begin : g_lvl
    localparam int CNT = tree_cnt(N, l);
    logic signed [OUT_W-1:0] s [CNT];
    if (l == 0) begin : g_in
      for (genvar j = 0; j < CNT; j++) begin : g_j
        assign s[j] = OUT_W'($signed(in_data[j]));
      end
    end else begin : g_add
      localparam int PCNT = tree_cnt(N, l - 1);
      for (genvar j = 0; j < CNT; j++) begin : g_j
        if (2*j + 1 < PCNT) begin : g_sum
          always_ff @(posedge clk) s[j] <= g_lvl[l-1].s[2*j] + g_lvl[l-1].s[2*j+1];
        end else begin : g_pass
          always_ff @(posedge clk) s[j] <= g_lvl[l-1].s[2*j];
        end
      end
    end
  end

  assign sum = g_lvl[D].s[0];
endmodule

// File: rtl/conv_3x3_pe.sv
// 3x3 conv PE: multiply, adder tree, channel-group accumulate, leaky/round/saturate.
module conv_3x3_pe import conv_pkg::*; #(
  parameter int CIN_PAR     = 8,
  parameter int COUT_PAR    = 2,
  parameter int ACC_W       = ACC_W_DEF,
  parameter int LEAKY_SHIFT = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 valid_in,
  input  logic                                 last_channel,
  input  logic [0:2][0:2][CIN_PAR*DATA_W-1:0]  pixels,
  input  logic [COUT_PAR*9*CIN_PAR*DATA_W-1:0] weights,
  input  logic [COUT_PAR*ACC_W-1:0]            bias,
  input  logic [4:0]                           quant_shift,
  input  logic                                 relu_en,
  output logic [COUT_PAR*ACC_W-1:0]            out_acc,
  output logic [COUT_PAR*DATA_W-1:0]           out_q,
  output logic                                 data_valid
);
  localparam int NPROD = 9 * CIN_PAR;
  localparam int D     = tree_depth(NPROD);
  localparam int SUM_W = PROD_W + D;

  typedef struct packed {
    logic                           last;
    logic                           relu;
    logic [4:0]                     shift;
    logic [COUT_PAR-1:0][ACC_W-1:0] bias;
  } sb_t;

  function automatic logic [DATA_W-1:0] post_fn(input logic [ACC_W-1:0] a,
                                                input logic relu, input logic [4:0] sh);
    logic signed [WIDE_W-1:0] v;
    v = WIDE_W'($signed(a));
    if (relu && v < 0) v = v >>> LEAKY_SHIFT;
    return sat_int8(round_shift(v, sh));
  endfunction

  // S1: products plus sideband that rides alongside the tree.
  logic [COUT_PAR-1:0][NPROD-1:0][PROD_W-1:0] prod_d, prod_q;
  logic s1_vld_q;
  sb_t  sb_d;
  sb_t  sb_q [0:D];

  for (genvar f = 0; f < COUT_PAR; f++) begin : g_f
    for (genvar i = 0; i < NPROD; i++) begin : g_i
      localparam int R = i / (3 * CIN_PAR);
      localparam int K = (i / CIN_PAR) % 3;
      localparam int C = i % CIN_PAR;
      assign prod_d[f][i] = mul8(pixels[R][K][C*DATA_W +: DATA_W],
                                 weights[(f*NPROD + i)*DATA_W +: DATA_W]);
    end
  end

  always_comb begin
    sb_d       = '0;
    sb_d.last  = last_channel;
    sb_d.relu  = relu_en;
    sb_d.shift = quant_shift;
    sb_d.bias  = bias;
  end

  always_ff @(posedge clk) begin
    if (rst) s1_vld_q <= 1'b0;
    else     s1_vld_q <= valid_in;
    prod_q   <= prod_d;
    sb_q[0]  <= sb_d;
    for (int l = 1; l <= D; l++) sb_q[l] <= sb_q[l-1];
  end

  logic [COUT_PAR-1:0]            tree_vld;
  logic [COUT_PAR-1:0][SUM_W-1:0] tree_sum;

  for (genvar f = 0; f < COUT_PAR; f++) begin : g_tree
    adder_tree_pipe #(.N(NPROD), .IN_W(PROD_W)) u_tree (
      .clk     (clk),
      .rst     (rst),
      .vld_in  (s1_vld_q),
      .in_data (prod_q[f]),
      .vld_out (tree_vld[f]),
      .sum     (tree_sum[f])
    );
  end

  // Accumulate: bias enters with the first group of each pixel, wraps at ACC_W.
  logic                           tv;
  logic [COUT_PAR-1:0][ACC_W-1:0] acc_d, acc_q;
  logic                           first_d, first_q, acc_vld_d, acc_vld_q;
  logic                           relu_q;
  logic [4:0]                     shift_q;

  assign tv = &tree_vld;

  always_comb begin
    acc_d     = acc_q;
    first_d   = first_q;
    acc_vld_d = 1'b0;
    if (tv) begin
      for (int f = 0; f < COUT_PAR; f++)
        acc_d[f] = (first_q ? sb_q[D].bias[f] : acc_q[f]) + ACC_W'($signed(tree_sum[f]));
      first_d   = sb_q[D].last;
      acc_vld_d = sb_q[D].last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      first_q   <= 1'b1;
      acc_vld_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      first_q   <= first_d;
      acc_vld_q <= acc_vld_d;
    end
    relu_q  <= sb_q[D].relu;
    shift_q <= sb_q[D].shift;
  end

  // Post stage then output register.
  logic [COUT_PAR-1:0][ACC_W-1:0]  post_acc_q, out_acc_d, out_acc_q;
  logic [COUT_PAR-1:0][DATA_W-1:0] post_qv_d, post_qv_q, out_q_d, out_q_q;
  logic                            post_vld_q, data_valid_q;

  always_comb begin
    post_qv_d = '0;
    for (int f = 0; f < COUT_PAR; f++) post_qv_d[f] = post_fn(acc_q[f], relu_q, shift_q);
  end

  always_comb begin
    out_acc_d = out_acc_q;
    out_q_d   = out_q_q;
    if (post_vld_q) begin
      out_acc_d = post_acc_q;
      out_q_d   = post_qv_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      post_vld_q   <= 1'b0;
      post_acc_q   <= '0;
      post_qv_q    <= '0;
      out_acc_q    <= '0;
      out_q_q      <= '0;
      data_valid_q <= 1'b0;
    end else begin
      post_vld_q   <= acc_vld_q;
      post_acc_q   <= acc_q;
      post_qv_q    <= post_qv_d;
      out_acc_q    <= out_acc_d;
      out_q_q      <= out_q_d;
      data_valid_q <= post_vld_q;
    end
  end

  assign out_acc    = out_acc_q;
  assign out_q      = out_q_q;
  assign data_valid = data_valid_q;
endmodule

// File: tb/tb_conv_3x3_pe.sv
// Randomized + directed scoreboard bench for conv_3x3_pe.
module tb_conv_3x3_pe;
  localparam int CIN = 8, COUT = 2, AW = 32, LK = 3, NP = 9 * CIN, LAT = 10;

  logic clk = 1'b0, rst = 1'b1, valid_in = 1'b0, last_channel = 1'b0, relu_en = 1'b0;
  logic [0:2][0:2][CIN*8-1:0] pixels  = '0;
  logic [COUT*9*CIN*8-1:0]    weights = '0;
  logic [COUT*AW-1:0]         bias    = '0;
  logic [4:0]                 quant_shift = '0;
  logic [COUT*AW-1:0]         out_acc;
  logic [COUT*8-1:0]          out_q;
  logic                       data_valid;

  conv_3x3_pe #(.CIN_PAR(CIN), .COUT_PAR(COUT), .ACC_W(AW), .LEAKY_SHIFT(LK)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .last_channel(last_channel),
    .pixels(pixels), .weights(weights), .bias(bias), .quant_shift(quant_shift),
    .relu_en(relu_en), .out_acc(out_acc), .out_q(out_q), .data_valid(data_valid)
  );

  always #5 clk = ~clk;

  typedef struct { int acc[COUT]; int q[COUT]; int due; } exp_t;
  exp_t sbq[$];
  int n_chk = 0, n_fail = 0, cyc = 0;
  int pv[NP];
  int wv[COUT][NP];
  int bv[COUT];
  int m_acc[COUT];
  bit m_first = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference post-processing: floor-shift leaky slope, round half up, clamp to int8.
  function automatic int ref_q(input int acc, input bit relu, input int sh);
    longint v = acc;
    if (relu && v < 0) v = v >>> LK;
    if (sh > 0) v = (v + (longint'(1) << (sh - 1))) >>> sh;
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    return int'(v);
  endfunction

  task automatic set_all(input int p, input int w0, input int w1, input int b0, input int b1);
    for (int i = 0; i < NP; i++) begin pv[i] = p; wv[0][i] = w0; wv[1][i] = w1; end
    bv[0] = b0; bv[1] = b1;
  endtask

  task automatic issue(input bit last, input bit relu, input int sh);
    int part;
    exp_t e;
    @(negedge clk);
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 3; k++)
        for (int c = 0; c < CIN; c++) pixels[r][k][c*8 +: 8] = pv[(r*3+k)*CIN + c][7:0];
    for (int f = 0; f < COUT; f++) begin
      for (int i = 0; i < NP; i++) weights[(f*NP + i)*8 +: 8] = wv[f][i][7:0];
      bias[f*AW +: AW] = bv[f];
    end
    valid_in = 1'b1; last_channel = last; relu_en = relu; quant_shift = sh[4:0];
    for (int f = 0; f < COUT; f++) begin
      part = 0;
      for (int i = 0; i < NP; i++) part += pv[i] * wv[f][i];
      m_acc[f] = m_first ? bv[f] + part : m_acc[f] + part;
    end
    m_first = last;
    if (last) begin
      for (int f = 0; f < COUT; f++) begin e.acc[f] = m_acc[f]; e.q[f] = ref_q(m_acc[f], relu, sh); end
      e.due = cyc + LAT + 1;
      sbq.push_back(e);
    end
  endtask

  // Idle cycles with junk on every qualified input.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_in = 1'b0; last_channel = 1'($urandom); relu_en = 1'($urandom);
      quant_shift = 5'($urandom); bias = {$urandom, $urandom};
      pixels[1][1] = {$urandom, $urandom};
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1; valid_in = 1'b0;
    sbq.delete(); m_first = 1'b1;
    for (int f = 0; f < COUT; f++) m_acc[f] = 0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    idle(1);
    while (sbq.size() > 0 && t < 4 * LAT) begin idle(1); t++; end
    if (sbq.size() > 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sbq.size());
      sbq.delete();
    end
    idle(3);
  endtask

  // Monitor: every data_valid must match the oldest expected result, on time.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (data_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_valid: data_valid=1 with no pending result at cycle %0d", cyc);
      end else begin
        e = sbq.pop_front();
        chk("latency", cyc, e.due);
        for (int f = 0; f < COUT; f++) begin
          chk($sformatf("out_acc[%0d]", f), $signed(out_acc[f*AW +: AW]), e.acc[f]);
          chk($sformatf("out_q[%0d]", f), $signed(out_q[f*8 +: 8]), e.q[f]);
        end
      end
    end
  end

  initial begin
    do_reset(3);
    @(posedge clk); #2;
    chk("reset_valid", data_valid, 0);
    chk("reset_acc", out_acc, 0);
    chk("reset_q", out_q, 0);

    set_all(1, 1, 1, 1, 1); issue(1, 0, 0); drain();                  // 73
    set_all(1, 1, 2, 1, 1); issue(0, 0, 0); idle(3);
    bv[0] = 99; bv[1] = -7; issue(1, 0, 0); drain();                  // 145/289, sat
    set_all(-1, 1, 1, 0, 0); issue(1, 0, 0); issue(1, 1, 0); drain(); // -72, leaky -9
    set_all(1, 1, 1, 0, 0); issue(1, 0, 4);                           // 72>>4 -> 5
    set_all(1, 1, 1, 1, 1); issue(0, 0, 0); issue(1, 0, 1);           // 145>>1 -> 73
    set_all(-1, 1, 1, 0, 0); issue(1, 0, 4); drain();                 // -4
    set_all(1, 1, 1, 1, 1); issue(1, 0, 0);
    bv[0] = 2; bv[1] = 2; issue(1, 0, 0);
    bv[0] = 3; bv[1] = 3; issue(1, 0, 0); drain();                    // 73,74,75 back to back
    set_all(1, 1, 1, 1, 1); issue(0, 0, 0); do_reset(1);
    issue(1, 0, 0); drain();                                          // 73, not 145
    issue(1, 0, 0); idle(2); do_reset(1); drain();                    // aborted pixel: no pulse

    for (int n = 0; n < 200; n++) begin
      for (int i = 0; i < NP; i++) begin
        pv[i] = int'($urandom_range(0, 255)) - 128;
        for (int f = 0; f < COUT; f++) wv[f][i] = int'($urandom_range(0, 255)) - 128;
      end
      for (int f = 0; f < COUT; f++) bv[f] = int'($urandom);
      issue($urandom_range(0, 2) == 0, 1'($urandom), int'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    set_all(0, 0, 0, 0, 0); issue(1, 0, 0); drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
